// File: rtl/ca_despreader_pkg.sv
// Shared constants, types and helpers for the C/A code despreader.
package ca_despreader_pkg;

    localparam int unsigned CODE_LEN   = 1023;
    localparam int unsigned LFSR_W     = 10;
    localparam int unsigned CHIP_IDX_W = 10;
    localparam int unsigned MATCH_W    = 11;
    localparam int unsigned CORR_W     = 12;

    // Bit i-1 set means stage i contributes to the feedback (stages numbered 1..10).
    localparam logic [LFSR_W-1:0] G1_TAPS = 10'b10_0000_0100;  // stages 3, 10
    localparam logic [LFSR_W-1:0] G2_TAPS = 10'b11_1010_0110;  // stages 2, 3, 6, 8, 9, 10

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    // Return stage `sel` (1..10) of an LFSR; any other selector reads as 0.
    function automatic logic tap_bit(input logic [LFSR_W-1:0] g, input logic [3:0] sel);
        logic r;
        r = 1'b0;
        for (int i = 1; i <= int'(LFSR_W); i++) begin
            if (sel == 4'(i)) begin
                r = g[i-1];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ca_lfsr_pair.sv
// G1/G2 Gold-code generator pair with reload-to-all-ones, step enable and tap-selected chip.
module ca_lfsr_pair
    import ca_despreader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       advance,
    input  logic [3:0] t0,
    input  logic [3:0] t1,
    output logic       chip
);

    logic [LFSR_W-1:0] g1_q, g1_d;
    logic [LFSR_W-1:0] g2_q, g2_d;

    // Next LFSR state: reload wins over a step; stages shift toward stage 10.
    always_comb begin
        g1_d = g1_q;
        g2_d = g2_q;
        if (load) begin
            g1_d = '1;
            g2_d = '1;
        end else if (advance) begin
            g1_d = {g1_q[LFSR_W-2:0], ^(g1_q & G1_TAPS)};
            g2_d = {g2_q[LFSR_W-2:0], ^(g2_q & G2_TAPS)};
        end
    end

    // LFSR registers, synchronous active-low reset to all-ones.
    always_ff @(posedge clk) begin
        if (!rst) begin
            g1_q <= '1;
            g2_q <= '1;
        end else begin
            g1_q <= g1_d;
            g2_q <= g2_d;
        end
    end

    assign chip = g1_q[LFSR_W-1] ^ tap_bit(g2_q, t0) ^ tap_bit(g2_q, t1);

endmodule

// File: rtl/ca_despreader.sv
// Hard-decision C/A code despreader: correlates received chips against a local
// Gold code over 1023-chip epochs and reports 2*matches-1023 per epoch.
module ca_despreader
    import ca_despreader_pkg::*;
#(
    parameter int unsigned EPOCH_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic [3:0]               t0,
    input  logic [3:0]               t1,
    input  logic                     rx_valid,
    input  logic                     rx_chip,
    input  logic                     slip,
    output logic                     busy,
    output logic signed [CORR_W-1:0] corr,
    output logic                     corr_valid,
    output logic [EPOCH_W-1:0]       epoch_cnt
);

    localparam logic [CHIP_IDX_W-1:0] LastChip = CHIP_IDX_W'(CODE_LEN - 1);

    state_e                  state_q, state_d;
    logic [CHIP_IDX_W-1:0]   chip_idx_q, chip_idx_d;
    logic [MATCH_W-1:0]      match_q, match_d;
    logic [3:0]              t0_q, t0_d;
    logic [3:0]              t1_q, t1_d;
    logic [CORR_W-1:0]       corr_q, corr_d;
    logic                    corr_valid_q, corr_valid_d;
    logic [EPOCH_W-1:0]      epoch_cnt_q, epoch_cnt_d;

    logic                    local_chip;
    logic                    lfsr_load;
    logic                    lfsr_adv;
    logic [MATCH_W-1:0]      match_inc;
    logic [CORR_W-1:0]       corr_calc;

    ca_lfsr_pair u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (lfsr_load),
        .advance (lfsr_adv),
        .t0      (t0_q),
        .t1      (t1_q),
        .chip    (local_chip)
    );

    // Match count including the chip on the bus, and the epoch result it would give.
    // 2*1023 fits in 12 bits, so modular subtraction yields the correct signed value.
    assign match_inc = match_q + MATCH_W'(rx_chip == local_chip);
    assign corr_calc = {match_inc, 1'b0} - CORR_W'(CODE_LEN);

    // FSM and accumulation: start beats everything, then stop, then chip counting.
    always_comb begin
        state_d      = state_q;
        chip_idx_d   = chip_idx_q;
        match_d      = match_q;
        t0_d         = t0_q;
        t1_d         = t1_q;
        corr_d       = corr_q;
        corr_valid_d = 1'b0;
        epoch_cnt_d  = epoch_cnt_q;
        lfsr_load    = 1'b0;
        lfsr_adv     = 1'b0;

        if (start) begin
            state_d     = StRun;
            chip_idx_d  = '0;
            match_d     = '0;
            t0_d        = t0;
            t1_d        = t1;
            epoch_cnt_d = '0;
            lfsr_load   = 1'b1;
        end else if (state_q == StRun) begin
            if (stop) begin
                state_d = StIdle;
            end else if (rx_valid && !slip) begin
                if (chip_idx_q == LastChip) begin
                    corr_d       = corr_calc;
                    corr_valid_d = 1'b1;
                    epoch_cnt_d  = epoch_cnt_q + EPOCH_W'(1);
                    chip_idx_d   = '0;
                    match_d      = '0;
                    lfsr_load    = 1'b1;
                end else begin
                    chip_idx_d = chip_idx_q + CHIP_IDX_W'(1);
                    match_d    = match_inc;
                    lfsr_adv   = 1'b1;
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            chip_idx_q   <= '0;
            match_q      <= '0;
            t0_q         <= '0;
            t1_q         <= '0;
            corr_q       <= '0;
            corr_valid_q <= 1'b0;
            epoch_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            chip_idx_q   <= chip_idx_d;
            match_q      <= match_d;
            t0_q         <= t0_d;
            t1_q         <= t1_d;
            corr_q       <= corr_d;
            corr_valid_q <= corr_valid_d;
            epoch_cnt_q  <= epoch_cnt_d;
        end
    end

    assign busy       = (state_q == StRun);
    assign corr       = corr_q;
    assign corr_valid = corr_valid_q;
    assign epoch_cnt  = epoch_cnt_q;

endmodule

// File: tb/tb_ca_despreader.sv
// Self-checking bench for ca_despreader: scoreboard of expected epoch results.
module tb_ca_despreader;

    localparam int EPOCH_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [3:0]        t0 = '0;
    logic [3:0]        t1 = '0;
    logic              rx_valid = 1'b0;
    logic              rx_chip = 1'b0;
    logic              slip = 1'b0;
    logic              busy;
    logic signed [11:0] corr;
    logic              corr_valid;
    logic [EPOCH_W-1:0] epoch_cnt;

    ca_despreader #(.EPOCH_W(EPOCH_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .t0         (t0),
        .t1         (t1),
        .rx_valid   (rx_valid),
        .rx_chip    (rx_chip),
        .slip       (slip),
        .busy       (busy),
        .corr       (corr),
        .corr_valid (corr_valid),
        .epoch_cnt  (epoch_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int corr;
        int epoch;
        int cyc;
    } exp_t;
    exp_t sb_q[$];

    logic [1022:0] prn1, prn2, ref_code;
    int sb_idx = 0;
    int sb_match = 0;
    int exp_epoch = 0;
    int last_corr = 0;

    // Reference Gold-code generator written from the stage equations.
    task automatic gen_code(input int a, input int b, output logic [1022:0] code);
        logic g1 [1:10];
        logic g2 [1:10];
        logic f1, f2;
        for (int k = 1; k <= 10; k++) begin
            g1[k] = 1'b1;
            g2[k] = 1'b1;
        end
        for (int i = 0; i < 1023; i++) begin
            code[i] = g1[10] ^ g2[a] ^ g2[b];
            f1 = g1[3] ^ g1[10];
            f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
            for (int k = 10; k >= 2; k--) begin
                g1[k] = g1[k-1];
                g2[k] = g2[k-1];
            end
            g1[1] = f1;
            g2[1] = f2;
        end
    endtask

    // Scoreboard consumer: every corr_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (corr_valid !== 1'b0) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_corr_valid: got corr_valid=%b corr=%0d, required no pulse",
                         corr_valid, corr);
            end else begin
                e = sb_q.pop_front();
                if (int'(corr) !== e.corr) begin
                    failures++;
                    $display("FAIL epoch_corr: got %0d, required %0d", corr, e.corr);
                end
                checks++;
                if (int'(epoch_cnt) !== (e.epoch % (1 << EPOCH_W))) begin
                    failures++;
                    $display("FAIL epoch_cnt_at_pulse: got %0d, required %0d", epoch_cnt,
                             e.epoch % (1 << EPOCH_W));
                end
                checks++;
                if (cyc !== e.cyc + 1) begin
                    failures++;
                    $display("FAIL corr_latency: got cycle %0d, required %0d", cyc, e.cyc + 1);
                end
            end
        end
    end

    task automatic do_start(input int a, input int b, input bit with_stop);
        @(negedge clk);
        start = 1'b1;
        stop = with_stop;
        t0 = 4'(a);
        t1 = 4'(b);
        rx_valid = 1'b0;
        slip = 1'b0;
        gen_code(a, b, ref_code);
        sb_idx = 0;
        sb_match = 0;
        exp_epoch = 0;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        t0 = 4'd0;
        t1 = 4'd0;
    endtask

    task automatic send_chip(input logic c, input int gap_pct);
        while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
            @(negedge clk);
            rx_valid = 1'b0;
            slip = 1'b0;
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_chip = c;
        slip = 1'b0;
        if (c == ref_code[sb_idx]) sb_match++;
        if (sb_idx == 1022) begin
            exp_epoch++;
            last_corr = 2 * sb_match - 1023;
            sb_q.push_back('{last_corr, exp_epoch, cyc});
            sb_idx = 0;
            sb_match = 0;
        end else begin
            sb_idx++;
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        rx_valid = 1'b0;
        slip = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        idle_cycle();
        for (int i = 0; i < 8 && sb_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: got %0d pending results, required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy: got %b, required 0", busy);
        end
        checks++;
        if (corr !== 12'sd0) begin
            failures++; $display("FAIL reset_corr: got %0d, required 0", corr);
        end
        checks++;
        if (corr_valid !== 1'b0) begin
            failures++; $display("FAIL reset_corr_valid: got %b, required 0", corr_valid);
        end
        checks++;
        if (epoch_cnt !== '0) begin
            failures++; $display("FAIL reset_epoch_cnt: got %0d, required 0", epoch_cnt);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_prn1_match();
        logic [9:0] head;
        for (int i = 0; i < 10; i++) head[9-i] = prn1[i];
        checks++;
        if (head !== 10'b1100100000) begin
            failures++; $display("FAIL prn1_head: got %b, required 1100100000", head);
        end
        do_start(2, 6, 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL start_busy: got %b, required 1", busy);
        end
        for (int i = 0; i < 1023; i++) send_chip(prn1[i], 0);
        wait_drain("prn1");
        checks++;
        if (int'(corr) !== 1023 || epoch_cnt !== 8'd1) begin
            failures++;
            $display("FAIL prn1_result: got corr=%0d epoch=%0d, required corr=1023 epoch=1",
                     corr, epoch_cnt);
        end
    endtask

    task automatic test_inverted_and_cross();
        do_start(2, 6, 1'b0);
        for (int i = 0; i < 1023; i++) send_chip(~prn1[i], 0);
        wait_drain("inverted");
        checks++;
        if (int'(corr) !== -1023) begin
            failures++; $display("FAIL inverted_corr: got %0d, required -1023", corr);
        end
        do_start(3, 7, 1'b0);
        for (int i = 0; i < 1023; i++) send_chip(prn1[i], 0);
        wait_drain("cross");
        checks++;
        if (int'(corr) > 65 || int'(corr) < -65) begin
            failures++; $display("FAIL cross_corr_bound: got %0d, required |corr|<=65", corr);
        end
    endtask

    task automatic test_slip();
        do_start(2, 6, 1'b0);
        // Delayed stream: the previous period's last chip arrives first and is slipped away.
        @(negedge clk);
        rx_valid = 1'b1;
        rx_chip = prn1[1022];
        slip = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        slip = 1'b1;
        for (int i = 0; i < 1023; i++) send_chip(prn1[i], 0);
        wait_drain("slip");
        checks++;
        if (int'(corr) !== 1023) begin
            failures++; $display("FAIL slip_corr: got %0d, required 1023", corr);
        end
    endtask

    task automatic test_gaps();
        do_start(2, 6, 1'b0);
        for (int e = 0; e < 3; e++) begin
            for (int i = 0; i < 1023; i++) send_chip(prn1[i], 30);
        end
        wait_drain("gaps");
        checks++;
        if (epoch_cnt !== 8'd3 || int'(corr) !== 1023) begin
            failures++;
            $display("FAIL gaps_result: got corr=%0d epoch=%0d, required corr=1023 epoch=3",
                     corr, epoch_cnt);
        end
    endtask

    task automatic test_stop();
        do_start(2, 6, 1'b0);
        for (int i = 0; i < 500; i++) send_chip(prn1[i], 0);
        @(negedge clk);
        stop = 1'b1;
        rx_valid = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        rx_valid = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL stop_busy: got %b, required 0", busy);
        end
        checks++;
        if (int'(corr) !== last_corr) begin
            failures++; $display("FAIL stop_corr_hold: got %0d, required %0d", corr, last_corr);
        end
        // Chips and slips in IDLE must be ignored for more than a full epoch.
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_chip = prn1[i % 1023];
            slip = (i % 7 == 0);
        end
        idle_cycle();
        checks++;
        if (epoch_cnt !== 8'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_ignore: got epoch=%0d busy=%b, required epoch=0 busy=0",
                     epoch_cnt, busy);
        end
    endtask

    task automatic test_reset_mid();
        do_start(2, 6, 1'b0);
        for (int i = 0; i < 500; i++) send_chip(~prn1[i], 0);
        @(negedge clk);
        rst = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || corr !== 12'sd0 || corr_valid !== 1'b0 || epoch_cnt !== '0) begin
            failures++;
            $display("FAIL reset_mid: got busy=%b corr=%0d cv=%b epoch=%0d, required all 0",
                     busy, corr, corr_valid, epoch_cnt);
        end
        rst = 1'b1;
        last_corr = 0;
        @(negedge clk);
    endtask

    task automatic test_restart();
        do_start(2, 6, 1'b1);
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL start_stop_same: got busy=%b, required 1", busy);
        end
        for (int i = 0; i < 1023; i++) send_chip(prn1[i], 0);
        for (int i = 0; i < 700; i++) send_chip(~prn1[i], 0);
        wait_drain("pre_restart");
        do_start(2, 6, 1'b0);
        checks++;
        if (epoch_cnt !== 8'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL restart_clear: got epoch=%0d busy=%b, required epoch=0 busy=1",
                     epoch_cnt, busy);
        end
        for (int i = 0; i < 1023; i++) send_chip(prn1[i], 0);
        wait_drain("restart");
        checks++;
        if (epoch_cnt !== 8'd1 || int'(corr) !== 1023) begin
            failures++;
            $display("FAIL restart_result: got corr=%0d epoch=%0d, required corr=1023 epoch=1",
                     corr, epoch_cnt);
        end
    endtask

    initial begin
        gen_code(2, 6, prn1);
        gen_code(3, 7, prn2);
        ref_code = prn1;
        test_reset();
        test_prn1_match();
        test_inverted_and_cross();
        test_slip();
        test_gaps();
        test_stop();
        test_reset_mid();
        test_restart();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish by cycle %0d, required completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
